cache_control: RTL
==================

# cache_control

Sequencing FSM for the direct-mapped, write-back cache built from the `array` storage instances (valid, dirty, tag, data). It accepts one CPU request at a time, decides hit or miss from the datapath's compare result, and runs the write-back and line-fill transactions to physical memory. It drives every array load strobe and datapath mux select, and keeps saturating hit, miss and write-back counters for performance readout.

## Interface
Parameters:
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`, input, 1: sole clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `mem_read`, input, 1: CPU read request; held until `mem_resp`.
- `mem_write`, input, 1: CPU write request; held until `mem_resp`.
- `mem_resp`, output, 1: one-cycle completion pulse to the CPU.
- `hit`, input, 1: datapath compare result (valid && tag match) for the current index.
- `dirty`, input, 1: dirty bit of the current index.
- `pmem_read`, output, 1: line-fill request to memory; held until `pmem_resp`.
- `pmem_write`, output, 1: line write-back request; held until `pmem_resp`.
- `pmem_resp`, input, 1: memory completion, one cycle.
- `load_tag`, output, 1: tag array write strobe.
- `load_valid`, output, 1: valid array write strobe.
- `load_dirty`, output, 1: dirty array write strobe.
- `load_data`, output, 1: data array write strobe.
- `valid_in`, output, 1: valid bit value written.
- `dirty_in`, output, 1: dirty bit value written.
- `data_sel`, output, 1: 0 = CPU write-merged line, 1 = line from pmem.
- `addr_sel`, output, 1: 0 = CPU address to pmem, 1 = {stored tag, index} (write-back address).
- `hit_count`, output, `CNT_W`: requests that hit on first compare.
- `miss_count`, output, `CNT_W`: requests that missed on first compare.
- `wb_count`, output, `CNT_W`: write-backs started.

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE: all strobes and requests low. If `mem_read | mem_write`, go to COMPARE; clear the `retry` flag.
- COMPARE on hit: pulse `mem_resp`. On a write, also assert `load_data` (`data_sel`=0) and `load_dirty` (`dirty_in`=1). Go to IDLE. Increment `hit_count` only if `retry`=0.
- COMPARE on miss with `dirty`=1: go to WRITEBACK and increment `miss_count` and `wb_count`.
- COMPARE on miss with `dirty`=0: go to FILL and increment `miss_count`.
- WRITEBACK: `pmem_write`=1, `addr_sel`=1. When `pmem_resp` arrives, go to FILL.
- FILL: `pmem_read`=1, `addr_sel`=0. On `pmem_resp`, in that same cycle assert `load_data` (`data_sel`=1), `load_tag`, `load_valid` (`valid_in`=1) and `load_dirty` (`dirty_in`=0). Set `retry`=1 and go to COMPARE, where the access now hits and completes; a write merges in that cycle.
- `mem_read` and `mem_write` both high: treated as a write.
- CPU request dropped while in COMPARE: go to IDLE, no `mem_resp`, no array writes, no counter change.
- CPU request dropped during WRITEBACK or FILL: the memory transaction still runs to `pmem_resp` and the fill still loads the arrays; the FSM then goes to IDLE instead of COMPARE.
- `pmem_read` and `pmem_write` are never high together.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset, asserted asynchronously: state=IDLE, `retry`=0, all 1-bit outputs 0, all counters 0. Reset asserted mid-WRITEBACK or mid-FILL drops `pmem_*` immediately.
- All outputs are Moore/Mealy decodes of registered state plus the current `hit`, `dirty` and `pmem_resp`. There are no output registers.
- Request sampled at edge 0 → COMPARE in cycle 1.
- Hit: `mem_resp` in cycle 1, so latency is 2 edges.
- Clean miss: FILL from cycle 2. If `pmem_resp` arrives in cycle k, then COMPARE in k+1 and `mem_resp` in k+1.
- Dirty miss: WRITEBACK from cycle 2, then FILL, then COMPARE.
- The post-fill COMPARE relies on committed array contents; the arrays' same-cycle write bypass is not required for correctness.
- Back-to-back requests: the earliest the next request enters COMPARE is 2 cycles after `mem_resp`, because IDLE is always visited once.

## Structure
- Package `cache_ctrl_pkg` holds:
  - the `cache_state_e` enum (IDLE, COMPARE, WRITEBACK, FILL);
  - `DATA_SEL_CPU`/`DATA_SEL_PMEM`;
  - `ADDR_SEL_CPU`/`ADDR_SEL_WB`.
- Sub-module `sat_counter`: width parameter, `clk`, `rst_n`, `inc`, `count`. Instantiated three times.
- The FSM uses a single `always_ff` state register plus `always_comb` next-state and output logic, with defaults at the top of the block.

## Test plan
- Read hit: set `hit`=1 and assert `mem_read` at edge 0 → `mem_resp` high in cycle 1 only; all `load_*` stay 0; `hit_count`=1.
- Write hit: set `hit`=1 and assert `mem_write` → in cycle 1, `load_data`=1, `data_sel`=0, `load_dirty`=1, `dirty_in`=1 and `mem_resp`=1.
- Clean read miss with `hit`=0, `dirty`=0 and `pmem_resp` in cycle 4:
  - `pmem_read` is high in cycles 2–4;
  - cycle 4 has all four loads, `valid_in`=1 and `data_sel`=1;
  - bench raises `hit`, and `mem_resp` follows in cycle 5;
  - final counts: `miss_count`=1, `hit_count`=0.
- Dirty write miss: `pmem_write` with `addr_sel`=1 until `pmem_resp`, then `pmem_read` until `pmem_resp`, then the merge write and `mem_resp`; `wb_count`=1 and `miss_count`=1.
- Reset mid-FILL: pull `rst_n` low in cycle 3 → `pmem_read` drops without waiting for a clock edge; state is IDLE and all counters read 0 after release.
- Saturation: with `CNT_W`=2, run 5 read hits → `hit_count`=3.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared state encoding and mux-select constants for the
//               write-back cache sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } cache_state_e;

  localparam logic DATA_SEL_CPU  = 1'b0;
  localparam logic DATA_SEL_PMEM = 1'b1;

  localparam logic ADDR_SEL_CPU  = 1'b0;
  localparam logic ADDR_SEL_WB   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module      : cache_control
// Description : Hit/miss sequencer for a direct-mapped write-back cache with
//               write-back, line fill and saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_control
  import cache_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic             dirty,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic             load_tag,
  output logic             load_valid,
  output logic             load_dirty,
  output logic             load_data,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             data_sel,
  output logic             addr_sel,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  cache_state_e r_state;
  cache_state_e w_next_state;
  logic         r_retry;
  logic         w_req;
  logic         w_hit_inc;
  logic         w_miss_inc;
  logic         w_wb_inc;

  assign w_req = mem_read | mem_write;

  // retry marks the post-fill compare so its hit is not counted a second time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_retry <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && w_req) begin
        r_retry <= 1'b0;
      end else if ((r_state == FILL) && pmem_resp) begin
        r_retry <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    load_tag     = 1'b0;
    load_valid   = 1'b0;
    load_dirty   = 1'b0;
    load_data    = 1'b0;
    valid_in     = 1'b0;
    dirty_in     = 1'b0;
    data_sel     = DATA_SEL_CPU;
    addr_sel     = ADDR_SEL_CPU;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    w_wb_inc     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next_state = COMPARE;
        end
      end

      COMPARE: begin
        if (!w_req) begin
          w_next_state = IDLE;
        end else if (hit) begin
          mem_resp     = 1'b1;
          w_hit_inc    = ~r_retry;
          w_next_state = IDLE;
          // a write (including read+write) merges CPU data into the line
          if (mem_write) begin
            load_data  = 1'b1;
            data_sel   = DATA_SEL_CPU;
            load_dirty = 1'b1;
            dirty_in   = 1'b1;
          end
        end else begin
          w_miss_inc = 1'b1;
          if (dirty) begin
            w_wb_inc     = 1'b1;
            w_next_state = WRITEBACK;
          end else begin
            w_next_state = FILL;
          end
        end
      end

      WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = ADDR_SEL_WB;
        if (pmem_resp) begin
          w_next_state = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        addr_sel  = ADDR_SEL_CPU;
        if (pmem_resp) begin
          load_data    = 1'b1;
          data_sel     = DATA_SEL_PMEM;
          load_tag     = 1'b1;
          load_valid   = 1'b1;
          valid_in     = 1'b1;
          load_dirty   = 1'b1;
          dirty_in     = 1'b0;
          w_next_state = w_req ? COMPARE : IDLE;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_miss_inc),
    .count (miss_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_wb_inc),
    .count (wb_count)
  );

endmodule
`default_nettype wire
